// File: rtl/sd_cmd_sender.sv
// SD command sender: builds the 48-bit SPI command frame, streams it through the
// byte shifter, polls for the R1 response and closes the transaction with trail bytes.
module sd_cmd_sender #(
    parameter int MAX_POLL    = 8,
    parameter int TRAIL_BYTES = 1
) (
    input  logic        sclk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    input  logic [6:0]  cmd_crc,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  resp,
    output logic        cs_n,
    output logic [7:0]  sh_data,
    output logic        sh_start,
    input  logic        sh_done,
    input  logic [7:0]  sh_rdata
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SEND       = 3'd1;
    localparam logic [2:0] S_SEND_WAIT  = 3'd2;
    localparam logic [2:0] S_POLL       = 3'd3;
    localparam logic [2:0] S_POLL_WAIT  = 3'd4;
    localparam logic [2:0] S_TRAIL      = 3'd5;
    localparam logic [2:0] S_TRAIL_WAIT = 3'd6;
    localparam logic [2:0] S_FIN        = 3'd7;

    localparam logic [7:0] POLL_LIMIT  = 8'(MAX_POLL);
    localparam logic [7:0] TRAIL_LIMIT = 8'(TRAIL_BYTES);

    logic [2:0]  r_state;
    logic [2:0]  r_byte_cnt;
    logic [7:0]  r_poll_cnt;
    logic [7:0]  r_trail_cnt;
    logic [5:0]  r_idx;
    logic [31:0] r_arg;
    logic [6:0]  r_crc;
    logic        r_busy;
    logic        r_done;
    logic        r_timeout;
    logic [7:0]  r_resp;
    logic        r_cs_n;
    logic [7:0]  r_sh_data;
    logic        r_sh_start;

    logic [7:0]  w_frame_byte;
    logic        w_poll_last;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_frame_byte = 8'hFF;
        case (r_byte_cnt)
            3'd0: w_frame_byte = {2'b01, r_idx};
            3'd1: w_frame_byte = r_arg[31:24];
            3'd2: w_frame_byte = r_arg[23:16];
            3'd3: w_frame_byte = r_arg[15:8];
            3'd4: w_frame_byte = r_arg[7:0];
            3'd5: w_frame_byte = {r_crc, 1'b1};
            default: w_frame_byte = 8'hFF;
        endcase
    end

    assign w_poll_last = ((r_poll_cnt + 8'd1) == POLL_LIMIT);

    // NOTE: state registers use non-blocking assignments so all updates land together at the edge.
    always_ff @(posedge sclk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_byte_cnt  <= 3'd0;
            r_poll_cnt  <= 8'd0;
            r_trail_cnt <= 8'd0;
            r_idx       <= 6'd0;
            r_arg       <= 32'd0;
            r_crc       <= 7'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_resp      <= 8'hFF;
            r_cs_n      <= 1'b1;
            r_sh_data   <= 8'hFF;
            r_sh_start  <= 1'b0;
        end else begin
            r_sh_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx       <= cmd_idx;
                        r_arg       <= cmd_arg;
                        r_crc       <= cmd_crc;
                        r_timeout   <= 1'b0;
                        r_resp      <= 8'hFF;
                        r_busy      <= 1'b1;
                        r_cs_n      <= 1'b0;
                        r_byte_cnt  <= 3'd0;
                        r_poll_cnt  <= 8'd0;
                        r_trail_cnt <= 8'd0;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_sh_data  <= w_frame_byte;
                    r_sh_start <= 1'b1;
                    r_state    <= S_SEND_WAIT;
                end
                S_SEND_WAIT: begin
                    if (sh_done) begin
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                        if (r_byte_cnt == 3'd5) begin
                            r_poll_cnt <= 8'd0;
                            r_state    <= S_POLL;
                        end else begin
                            r_state <= S_SEND;
                        end
                    end
                end
                S_POLL: begin
                    r_sh_data  <= 8'hFF;
                    r_sh_start <= 1'b1;
                    r_state    <= S_POLL_WAIT;
                end
                S_POLL_WAIT: begin
                    if (sh_done) begin
                        r_poll_cnt <= r_poll_cnt + 8'd1;
                        if (!sh_rdata[7]) begin
                            r_resp  <= sh_rdata;
                            r_cs_n  <= 1'b1;
                            r_state <= S_TRAIL;
                        end else if (w_poll_last) begin
                            r_timeout <= 1'b1;
                            r_resp    <= 8'hFF;
                            r_cs_n    <= 1'b1;
                            r_state   <= S_TRAIL;
                        end else begin
                            r_state <= S_POLL;
                        end
                    end
                end
                // Trail count is checked before each byte, so zero trail bytes goes straight to FIN.
                S_TRAIL: begin
                    if (r_trail_cnt == TRAIL_LIMIT) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_sh_data  <= 8'hFF;
                        r_sh_start <= 1'b1;
                        r_state    <= S_TRAIL_WAIT;
                    end
                end
                S_TRAIL_WAIT: begin
                    if (sh_done) begin
                        r_trail_cnt <= r_trail_cnt + 8'd1;
                        r_state     <= S_TRAIL;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign timeout  = r_timeout;
    assign resp     = r_resp;
    assign cs_n     = r_cs_n;
    assign sh_data  = r_sh_data;
    assign sh_start = r_sh_start;

endmodule
